font_rom_arbiter: RTL and testbench

- Shares the single character font ROM (11-bit address, 8-bit row data, synchronous read) between several requesters.
- Requesters are the board letter overlay, a status or timer text line, and a player-name banner.
- Requester 0 is the real-time board letter path and has strict priority. All other requesters are served round-robin.
- Each granted read is tagged, tracked through the ROM latency, and its data is returned to the requester that issued it.
- Sits between the text/letter generators and the font ROM instance in the VGA drawing chain.

---
 rtl/font_rom_arbiter_pkg.sv | 17 +
 rtl/font_rom_arbiter_rr_priority_pick.sv | 45 ++++
 rtl/font_rom_arbiter.sv | 80 ++++++++
 tb/tb_font_rom_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/font_rom_arbiter_pkg.sv
// Shared constants for the font ROM arbiter: ROM geometry, requester port indices
// and the round-robin pointer advance rule.
package font_rom_arbiter_pkg;

  localparam int CHAR_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;

  localparam int REQ_LETTERS = 0;
  localparam int REQ_STATUS  = 1;
  localparam int REQ_BANNER  = 2;

  // Pointer after granting round-robin port k; port 0 never takes part in the rotation.
  function automatic int rr_next(input int k, input int num_req);
    return (k >= num_req - 1) ? 1 : k + 1;
  endfunction

endpackage

// File: rtl/font_rom_arbiter_rr_priority_pick.sv
// Combinational grant pick: port 0 wins outright, otherwise the first request
// found cyclically from rr_ptr among ports 1..NUM_REQ-1.
module rr_priority_pick
  import font_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  // Port number visited at search step k, starting at rr_ptr and wrapping to 1.
  function automatic int rr_slot(input logic [ID_W-1:0] ptr, input int k);
    int c;
    c = int'(ptr) - 1 + k;
    if (c >= NUM_REQ - 1) c = c - (NUM_REQ - 1);
    return c + 1;
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (req[REQ_LETTERS]) begin
      gnt[REQ_LETTERS] = 1'b1;
      gnt_idx          = ID_W'(REQ_LETTERS);
      gnt_any          = 1'b1;
    end else begin
      // Walk the search order backwards so the earliest hit is written last.
      for (int k = NUM_REQ - 2; k >= 0; k--) begin
        if (req[rr_slot(rr_ptr, k)]) begin
          gnt                    = '0;
          gnt[rr_slot(rr_ptr, k)] = 1'b1;
          gnt_idx                = ID_W'(rr_slot(rr_ptr, k));
          gnt_any                = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous-read font ROM among several text/letter requesters and
// routes each returned row back to the port whose read produced it.
module font_rom_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ROM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CHAR_ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [CHAR_ADDR_W-1:0]         rom_addr,
  input  logic [FONT_DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [FONT_DATA_W-1:0]         rsp_data,
  output logic                           busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 1 + ROM_LATENCY;

  logic [NUM_REQ-1:0]            pick_gnt;
  logic [ID_W-1:0]               pick_idx;
  logic                          pick_any;
  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CHAR_ADDR_W-1:0]        rom_addr_q, rom_addr_d;
  logic [DEPTH-1:0]              vld_q;
  logic [DEPTH-1:0][ID_W-1:0]    id_q;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Grants are suppressed while reset is held so no requester sees a phantom transfer.
  assign gnt = rst ? pick_gnt : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rom_addr_d = rom_addr_q;
    if (pick_any) begin
      rom_addr_d = req_addr[int'(pick_idx)*CHAR_ADDR_W +: CHAR_ADDR_W];
      if (pick_idx != ID_W'(REQ_LETTERS))
        rr_ptr_d = ID_W'(rr_next(int'(pick_idx), NUM_REQ));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= ID_W'(1);
      rom_addr_q <= '0;
      vld_q      <= '0;
      id_q       <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rom_addr_q <= rom_addr_d;
      // Stage 0 aligns with rom_addr; the tail aligns with rom_data.
      vld_q      <= {vld_q[DEPTH-2:0], pick_any};
      id_q       <= {id_q[DEPTH-2:0], pick_idx};
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (vld_q[DEPTH-1]) rsp_valid[id_q[DEPTH-1]] = 1'b1;
  end

  assign rom_addr = rom_addr_q;
  assign rsp_data = rom_data;
  assign busy     = |vld_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: a 3-port/latency-1 instance under directed steps and
// a 4-port/latency-3 instance under random traffic, both against a scoreboard model.
module tb_font_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:2047];

  logic [2:0]  req_a;
  logic [32:0] addr_a;
  logic [2:0]  gnt_a, rsp_valid_a;
  logic [10:0] rom_addr_a;
  logic [7:0]  rom_data_a, rsp_data_a, rd_a;
  logic        busy_a;

  logic [3:0]  req_b;
  logic [43:0] addr_b;
  logic [3:0]  gnt_b, rsp_valid_b;
  logic [10:0] rom_addr_b;
  logic [7:0]  rom_data_b, rsp_data_b, rd_b1, rd_b2, rd_b3;
  logic        busy_b;

  font_rom_arbiter #(.NUM_REQ(3), .ROM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .gnt(gnt_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rsp_valid(rsp_valid_a),
    .rsp_data(rsp_data_a), .busy(busy_a));

  font_rom_arbiter #(.NUM_REQ(4), .ROM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_b), .gnt(gnt_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rsp_valid(rsp_valid_b),
    .rsp_data(rsp_data_b), .busy(busy_b));

  // Font ROM models: registered read, extra output stages for the slower instance.
  always @(posedge clk) begin
    rd_a  <= mem[rom_addr_a];
    rd_b1 <= mem[rom_addr_b];
    rd_b2 <= rd_b1;
    rd_b3 <= rd_b2;
  end
  assign rom_data_a = rd_a;
  assign rom_data_b = rd_b3;

  typedef struct {
    int          due;
    int          id;
    logic [10:0] addr;
  } rsp_t;

  rsp_t        sb_a[$];
  rsp_t        sb_b[$];
  int          ptr_a, ptr_b, cyc;
  logic [10:0] last_a, last_b;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference arbitration: port 0 first, then ports ptr..n-1, then 1..ptr-1.
  function automatic int model_pick(input logic [7:0] r, input int n, input int ptr);
    if (r[0]) return 0;
    for (int c = ptr; c < n; c++) if (r[c]) return c;
    for (int c = 1; c < ptr; c++) if (r[c]) return c;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  // One clock cycle: check both DUTs at the falling edge, update the model, advance.
  task automatic tick(input bit dir, input logic [31:0] dir_gnt);
    int g;
    @(negedge clk);
    if (!rst) begin
      chk("rst_gnt_a", 32'(gnt_a), 0);
      chk("rst_rsp_valid_a", 32'(rsp_valid_a), 0);
      chk("rst_rom_addr_a", 32'(rom_addr_a), 0);
      chk("rst_busy_a", 32'(busy_a), 0);
      chk("rst_gnt_b", 32'(gnt_b), 0);
      chk("rst_rsp_valid_b", 32'(rsp_valid_b), 0);
      chk("rst_busy_b", 32'(busy_b), 0);
      ptr_a = 1; ptr_b = 1; last_a = '0; last_b = '0;
      sb_a.delete(); sb_b.delete();
    end else begin
      g = model_pick({5'b0, req_a}, 3, ptr_a);
      if (dir) chk("dir_gnt_a", 32'(gnt_a), dir_gnt);
      chk("gnt_a", 32'(gnt_a), onehot(g));
      chk("rom_addr_a", 32'(rom_addr_a), 32'(last_a));
      chk("busy_a", 32'(busy_a), 32'(sb_a.size() != 0));
      if (sb_a.size() != 0 && sb_a[0].due == cyc) begin
        chk("rsp_valid_a", 32'(rsp_valid_a), onehot(sb_a[0].id));
        chk("rsp_data_a", 32'(rsp_data_a), 32'(mem[sb_a[0].addr]));
        void'(sb_a.pop_front());
      end else begin
        chk("rsp_valid_a", 32'(rsp_valid_a), 0);
      end
      if (g >= 0) begin
        last_a = addr_a[11*g +: 11];
        sb_a.push_back('{cyc + 2, g, last_a});
        if (g != 0) ptr_a = (g == 2) ? 1 : g + 1;
      end

      g = model_pick({4'b0, req_b}, 4, ptr_b);
      chk("gnt_b", 32'(gnt_b), onehot(g));
      chk("rom_addr_b", 32'(rom_addr_b), 32'(last_b));
      chk("busy_b", 32'(busy_b), 32'(sb_b.size() != 0));
      if (sb_b.size() != 0 && sb_b[0].due == cyc) begin
        chk("rsp_valid_b", 32'(rsp_valid_b), onehot(sb_b[0].id));
        chk("rsp_data_b", 32'(rsp_data_b), 32'(mem[sb_b[0].addr]));
        void'(sb_b.pop_front());
      end else begin
        chk("rsp_valid_b", 32'(rsp_valid_b), 0);
      end
      if (g >= 0) begin
        last_b = addr_b[11*g +: 11];
        sb_b.push_back('{cyc + 4, g, last_b});
        if (g != 0) ptr_b = (g == 3) ? 1 : g + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    req_b  = 4'($urandom_range(0, 15));
    addr_b = 44'({$urandom(), $urandom()});
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom());
    cyc = 0; ptr_a = 1; ptr_b = 1; last_a = '0; last_b = '0;
    req_a  = 3'b111;
    addr_a = 33'({$urandom(), $urandom()});
    req_b  = 4'b1111;
    addr_b = 44'({$urandom(), $urandom()});

    // Reset held with all requests active, then release: port 0 first.
    tick(0, 0);
    tick(0, 0);
    rst = 1'b1;
    tick(1, 32'h1);

    // Single requester on port 1.
    req_a = 3'b010;
    addr_a[21:11] = 11'h412;
    tick(1, 32'h2);
    chk("dir_rom_addr_a", 32'(rom_addr_a), 32'h412);
    req_a = 3'b000;
    tick(0, 0);
    chk("dir_rsp_valid_a", 32'(rsp_valid_a), 32'h2);
    chk("dir_rsp_data_a", 32'(rsp_data_a), 32'(mem[11'h412]));
    tick(0, 0);
    tick(0, 0);

    // Round robin from a fresh pointer: 1,2,1,2.
    rst = 1'b0;
    tick(0, 0);
    rst = 1'b1;
    req_a = 3'b110;
    addr_a = 33'({$urandom(), $urandom()});
    tick(1, 32'h2);
    tick(1, 32'h4);
    tick(1, 32'h2);
    tick(1, 32'h4);
    req_a = 3'b000;
    repeat (4) tick(0, 0);

    // Priority: port 0 wins three times, pointer untouched, then port 1.
    req_a = 3'b111;
    tick(1, 32'h1);
    tick(1, 32'h1);
    tick(1, 32'h1);
    req_a = 3'b110;
    tick(1, 32'h2);
    req_a = 3'b000;
    repeat (4) tick(0, 0);

    // Reset while a port-2 read is in flight: it must vanish.
    req_a = 3'b100;
    tick(1, 32'h4);
    req_a = 3'b000;
    rst = 1'b0;
    #1;
    chk("midrst_busy_a", 32'(busy_a), 0);
    chk("midrst_busy_b", 32'(busy_b), 0);
    chk("midrst_rsp_valid_a", 32'(rsp_valid_a), 0);
    tick(0, 0);
    tick(0, 0);
    rst = 1'b1;
    repeat (5) tick(0, 0);

    // Random traffic on both instances.
    repeat (400) begin
      req_a  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : {2'($urandom_range(0, 3)), 1'b0};
      addr_a = 33'({$urandom(), $urandom()});
      tick(0, 0);
    end
    req_a = 3'b000;
    repeat (6) tick(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
